// File: rtl/core_seq.sv
// core_seq: multi-cycle instruction sequencer for the npc core.
// Fetches one instruction over a req/ack handshake, classifies its opcode,
// then steps the datapath through EXEC and write-back. Owns the PC, the
// retired-instruction counter and the sticky halt status.
// Optional feature: define SEQ_FETCH_TIMEOUT_EN to halt (halt_code=3) when a
// fetch goes FETCH_TIMEOUT cycles without an ack.
module core_seq #(
  parameter logic [31:0] RESET_PC      = 32'h8000_0000,
  parameter int          FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [2:0]  inst_type,
  output logic        exec_en,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic [31:0] retired,
  output logic        halted,
  output logic [1:0]  halt_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  localparam logic [2:0] TYPE_R       = 3'd0;
  localparam logic [2:0] TYPE_I       = 3'd1;
  localparam logic [2:0] TYPE_S       = 3'd2;
  localparam logic [2:0] TYPE_B       = 3'd3;
  localparam logic [2:0] TYPE_U       = 3'd4;
  localparam logic [2:0] TYPE_J       = 3'd5;
  localparam logic [2:0] TYPE_ILLEGAL = 3'd7;

  state_t state, state_next;

  logic        jump_taken;
  logic [31:0] jump_pc;
  logic        timeout_hit;
  logic        wb_writes;

  // Maps a 7-bit opcode to the instruction format used downstream.
  function automatic logic [2:0] classify(input logic [6:0] opcode);
    logic [2:0] t;
    case (opcode)
      7'b0110011: t = TYPE_R;
      7'b0010011,
      7'b0000011,
      7'b1100111,
      7'b1110011: t = TYPE_I;
      7'b0100011: t = TYPE_S;
      7'b1100011: t = TYPE_B;
      7'b0110111,
      7'b0010111: t = TYPE_U;
      7'b1101111: t = TYPE_J;
      default:    t = TYPE_ILLEGAL;
    endcase
    return t;
  endfunction

  assign imem_addr = pc;

  // Register-writing formats with a non-zero destination write back.
  assign wb_writes = ((inst_type == TYPE_R) || (inst_type == TYPE_I) ||
                      (inst_type == TYPE_U) || (inst_type == TYPE_J)) &&
                     (inst[11:7] != 5'd0);

`ifdef SEQ_FETCH_TIMEOUT_EN
  localparam int TO_W = (FETCH_TIMEOUT > 255) ? $clog2(FETCH_TIMEOUT + 1) : 8;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);

  logic [TO_W-1:0] fetch_wait;

  // Counts ack-less FETCH cycles; held at zero outside FETCH so every entry starts fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_wait <= '0;
    end else if (state != S_FETCH) begin
      fetch_wait <= '0;
    end else if (!imem_ack) begin
      fetch_wait <= fetch_wait + 1'b1;
    end
  end

  assign timeout_hit = (state == S_FETCH) && !imem_ack && (fetch_wait == TO_LAST);
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (FETCH_TIMEOUT != 0);
  assign timeout_hit        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded strobes.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    exec_en    = 1'b0;
    rf_we      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack)         state_next = S_DECODE;
        else if (timeout_hit) state_next = S_HALT;
      end
      S_DECODE: begin
        if ((inst == EBREAK_WORD) || (inst_type == TYPE_ILLEGAL)) state_next = S_HALT;
        else                                                      state_next = S_EXEC;
      end
      S_EXEC: begin
        exec_en    = 1'b1;
        state_next = S_WB;
      end
      S_WB: begin
        rf_we      = wb_writes;
        state_next = S_FETCH;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Architectural registers: instruction latch, redirect capture, PC, retire count, halt status.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      inst       <= 32'd0;
      inst_type  <= 3'd0;
      retired    <= 32'd0;
      halted     <= 1'b0;
      halt_code  <= 2'd0;
      jump_taken <= 1'b0;
      jump_pc    <= 32'd0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            inst      <= imem_rdata;
            inst_type <= classify(imem_rdata[6:0]);
          end else if (timeout_hit) begin
            halted    <= 1'b1;
            halt_code <= 2'd3;
          end
        end
        S_DECODE: begin
          if (inst == EBREAK_WORD) begin
            halted    <= 1'b1;
            halt_code <= 2'd1;
          end else if (inst_type == TYPE_ILLEGAL) begin
            halted    <= 1'b1;
            halt_code <= 2'd2;
          end
        end
        S_EXEC: begin
          jump_taken <= jump_valid;
          jump_pc    <= jump_target;
        end
        S_WB: begin
          pc      <= jump_taken ? jump_pc : pc + 32'd4;
          retired <= retired + 32'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_seq.sv
// Self-checking bench for core_seq: directed scenarios plus randomized
// instruction streams checked against a behavioural model of the sequencer.
module tb_core_seq;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [2:0]  inst_type;
  logic        exec_en;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        rf_we;
  logic [31:0] pc;
  logic [31:0] retired;
  logic        halted;
  logic [1:0]  halt_code;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_pc;
  logic [31:0] model_retired;

  core_seq #(
    .RESET_PC      (RESET_PC),
    .FETCH_TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_type   (inst_type),
    .exec_en     (exec_en),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .rf_we       (rf_we),
    .pc          (pc),
    .retired     (retired),
    .halted      (halted),
    .halt_code   (halt_code)
  );

  // Free-running core clock.
  always #5 clk = ~clk;

  // Safety net against a hung run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: instruction format from the opcode table.
  function automatic logic [2:0] modelType(input logic [31:0] w);
    logic [6:0] op;
    op = w[6:0];
    if (op == 7'h33) return 3'd0;
    if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73) return 3'd1;
    if (op == 7'h23) return 3'd2;
    if (op == 7'h63) return 3'd3;
    if (op == 7'h37 || op == 7'h17) return 3'd4;
    if (op == 7'h6F) return 3'd5;
    return 3'd7;
  endfunction

  function automatic logic modelWrites(input logic [31:0] w);
    logic [2:0] t;
    t = modelType(w);
    return (t == 3'd0 || t == 3'd1 || t == 3'd4 || t == 3'd5) && (w[11:7] != 5'd0);
  endfunction

  function automatic logic [1:0] modelHalt(input logic [31:0] w);
    if (w == EBREAK) return 2'd1;
    if (modelType(w) == 3'd7) return 2'd2;
    return 2'd0;
  endfunction

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pc"},        pc,                 RESET_PC);
    checkOutput({tag, "_retired"},   retired,            32'd0);
    checkOutput({tag, "_halted"},    32'(halted),        32'd0);
    checkOutput({tag, "_halt_code"}, 32'(halt_code),     32'd0);
    checkOutput({tag, "_imem_req"},  32'(imem_req),      32'd0);
    checkOutput({tag, "_exec_en"},   32'(exec_en),       32'd0);
    checkOutput({tag, "_rf_we"},     32'(rf_we),         32'd0);
    checkOutput({tag, "_inst"},      inst,               32'd0);
    checkOutput({tag, "_inst_type"}, 32'(inst_type),     32'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    start = 1'b1;
    imem_ack = 1'b0;
    jump_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    start = 1'b0;
    model_pc = RESET_PC;
    model_retired = 32'd0;
  endtask

  task automatic startRun();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drives one instruction from FETCH through WB (or into HALT) and checks each cycle.
  task automatic applyStimulus(input logic [31:0] word, input int ackDelay,
                               input logic jv, input logic [31:0] jt);
    logic [1:0] code;
    checkOutput("fetch_req",  32'(imem_req), 32'd1);
    checkOutput("fetch_addr", imem_addr,     model_pc);
    for (int i = 0; i < ackDelay; i++) begin
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      tick();
      checkOutput("wait_req",  32'(imem_req), 32'd1);
      checkOutput("wait_addr", imem_addr,     model_pc);
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    checkOutput("decode_inst", inst,            word);
    checkOutput("decode_type", 32'(inst_type),  32'(modelType(word)));
    checkOutput("decode_req",  32'(imem_req),   32'd0);
    checkOutput("decode_rfwe", 32'(rf_we),      32'd0);
    code = modelHalt(word);
    if (code != 2'd0) begin
      tick();
      checkOutput("halt_flag",    32'(halted),    32'd1);
      checkOutput("halt_code",    32'(halt_code), 32'(code));
      checkOutput("halt_req",     32'(imem_req),  32'd0);
      checkOutput("halt_pc",      pc,             model_pc);
      checkOutput("halt_retired", retired,        model_retired);
      return;
    end
    tick();
    checkOutput("exec_en",   32'(exec_en),  32'd1);
    checkOutput("exec_rfwe", 32'(rf_we),    32'd0);
    checkOutput("exec_pc",   pc,            model_pc);
    jump_valid = jv;
    jump_target = jt;
    tick();
    jump_valid = ~jv;
    jump_target = $urandom;
    checkOutput("wb_exec_en", 32'(exec_en),  32'd0);
    checkOutput("wb_rfwe",    32'(rf_we),    32'(modelWrites(word)));
    checkOutput("wb_req",     32'(imem_req), 32'd0);
    checkOutput("wb_pc",      pc,            model_pc);
    tick();
    jump_valid = 1'b0;
    model_pc = jv ? jt : model_pc + 32'd4;
    model_retired = model_retired + 32'd1;
    checkOutput("next_pc",      pc,             model_pc);
    checkOutput("next_retired", retired,        model_retired);
    checkOutput("next_rfwe",    32'(rf_we),     32'd0);
    checkOutput("next_req",     32'(imem_req),  32'd1);
    checkOutput("hold_inst",    inst,           word);
    checkOutput("hold_type",    32'(inst_type), 32'(modelType(word)));
  endtask

  initial begin
    logic [6:0]  legal_ops [9];
    logic [31:0] r;
    logic [31:0] w;

    legal_ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h6F};
    rst = 1'b1;
    start = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    jump_valid = 1'b0;
    jump_target = 32'd0;

    $display("[TB] reset and idle behaviour");
    doReset();
    checkResetState("reset");
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1;
      imem_rdata = 32'h0050_0093;
      tick();
      checkOutput("idle_req",  32'(imem_req), 32'd0);
      checkOutput("idle_inst", inst,          32'd0);
    end
    imem_ack = 1'b0;
    startRun();

    $display("[TB] directed instructions");
    applyStimulus(32'h0050_0093, 0, 1'b0, 32'd0);
    applyStimulus(32'h0000_0013, 0, 1'b0, 32'd0);
    applyStimulus(32'h0011_2023, 1, 1'b0, 32'd0);
    applyStimulus(32'h0080_00EF, 3, 1'b1, 32'h8000_0100);
    applyStimulus(32'h0000_0063, 0, 1'b0, 32'd0);
    applyStimulus(32'h1234_50B7, 2, 1'b0, 32'd0);

    $display("[TB] pc wrap and unaligned target");
    applyStimulus(32'h0050_0093, 0, 1'b1, 32'hFFFF_FFFC);
    applyStimulus(32'h0050_0093, 1, 1'b1, 32'h0000_1235);
    applyStimulus(32'h0050_0093, 0, 1'b1, 32'hFFFF_FFFC);
    applyStimulus(32'h0000_0013, 0, 1'b0, 32'd0);

    $display("[TB] randomized instruction stream");
    for (int n = 0; n < 24; n++) begin
      r = $urandom;
      w = {r[31:7], legal_ops[$urandom_range(0, 8)]};
      if (modelHalt(w) != 2'd0) w = 32'h0000_0013;
      r = $urandom;
      applyStimulus(w, $urandom_range(0, 3), 1'($urandom_range(0, 1)), r);
    end

    $display("[TB] ebreak halt is sticky");
    applyStimulus(EBREAK, 1, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      imem_ack = 1'b1;
      jump_valid = 1'b1;
      jump_target = $urandom;
      tick();
      checkOutput("sticky_halted", 32'(halted),    32'd1);
      checkOutput("sticky_code",   32'(halt_code), 32'd1);
      checkOutput("sticky_req",    32'(imem_req),  32'd0);
      checkOutput("sticky_rfwe",   32'(rf_we),     32'd0);
      checkOutput("sticky_exec",   32'(exec_en),   32'd0);
      checkOutput("sticky_pc",     pc,             model_pc);
    end
    start = 1'b0;
    imem_ack = 1'b0;
    jump_valid = 1'b0;

    $display("[TB] illegal opcode halt after reset recovery");
    doReset();
    checkResetState("recover");
    startRun();
    applyStimulus(32'h0000_0013, 0, 1'b0, 32'd0);
    applyStimulus(32'h0000_0000, 0, 1'b0, 32'd0);

    $display("[TB] reset in the middle of a fetch");
    doReset();
    startRun();
    applyStimulus(32'h0050_0093, 0, 1'b1, 32'h1234_5678);
    imem_ack = 1'b0;
    tick();
    checkOutput("midfetch_req", 32'(imem_req), 32'd1);
    rst = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'h0050_0093;
    tick();
    rst = 1'b0;
    imem_ack = 1'b0;
    model_pc = RESET_PC;
    model_retired = 32'd0;
    checkResetState("midfetch");

`ifdef SEQ_FETCH_TIMEOUT_EN
    $display("[TB] fetch timeout");
    doReset();
    startRun();
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("to_wait_req",    32'(imem_req), 32'd1);
      checkOutput("to_wait_halted", 32'(halted),   32'd0);
    end
    tick();
    checkOutput("to_halted", 32'(halted),    32'd1);
    checkOutput("to_code",   32'(halt_code), 32'd3);
    checkOutput("to_req",    32'(imem_req),  32'd0);

    doReset();
    startRun();
    for (int i = 0; i < 3; i++) tick();
    applyStimulus(32'h0050_0093, 0, 1'b0, 32'd0);
    checkOutput("to_ack_wins_halted", 32'(halted), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_seq.md
# core_seq

Multi-cycle instruction sequencer for the npc core. Fetches one instruction at a time over a req/ack instruction-memory handshake and latches it. It classifies the opcode into the instruction type consumed by the immediate extender and decoder, then steps the datapath through EXEC and write-back. It owns the PC, the retired-instruction counter and the halt status, and sits between instruction memory and the datapath (decoder, immediate extender, ALU, register file).

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- FETCH_TIMEOUT, 255, maximum FETCH cycles without ack (used only with SEQ_FETCH_TIMEOUT_EN)

Ports:
- clk  in  1  core clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  leaves IDLE; ignored in every other state
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, equal to pc
- imem_ack  in  1  fetch data valid; meaningful only while imem_req=1
- imem_rdata  in  32  instruction word, sampled on the edge where imem_req=1 and imem_ack=1
- inst  out  32  latched instruction
- inst_type  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal
- exec_en  out  1  one-cycle pulse in EXEC
- jump_valid  in  1  redirect request, sampled in EXEC
- jump_target  in  32  redirect PC, sampled in EXEC
- rf_we  out  1  register-file write strobe, asserted in WB only
- pc  out  32  PC of the current instruction
- retired  out  32  count of instructions completed through WB
- halted  out  1  sticky halt flag
- halt_code  out  2  0=none, 1=ebreak, 2=illegal opcode, 3=fetch timeout

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE -> FETCH when start=1.
- FETCH: imem_req=1 and imem_addr=pc, held until ack. On ack, inst <= imem_rdata and the state moves to DECODE.
- DECODE (1 cycle): inst_type is computed from inst[6:0]:
  - 0110011 -> R
  - 0010011, 0000011, 1100111, 1110011 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 0110111, 0010111 -> U
  - 1101111 -> J
  - anything else -> 7
- DECODE exits:
  - inst == 32'h0010_0073 (ebreak) -> HALT, halt_code=1.
  - inst_type == 7 -> HALT, halt_code=2.
  - Otherwise -> EXEC.
- EXEC (1 cycle): exec_en=1. jump_valid and jump_target are captured. -> WB.
- WB (1 cycle):
  - rf_we=1 iff inst_type ∈ {R, I, U, J} and inst[11:7] != 0.
  - pc <= captured jump_target if jump_valid was 1 in EXEC, else pc+4. The add is 32-bit and wraps modulo 2^32; the target is used unaligned-as-is.
  - retired <= retired+1, wrapping at 2^32.
  - -> FETCH.
- HALT: sticky. Only rst leaves it. start, imem_ack and jump inputs are ignored. No rf_we, no imem_req.
- inst and inst_type hold their values from DECODE through the next FETCH ack.

## Timing
- Reset values:
  - state=IDLE
  - pc=RESET_PC
  - inst=0, inst_type=0
  - retired=0
  - halted=0, halt_code=0
  - imem_req=0, exec_en=0, rf_we=0
- Outputs are registered state or decoded directly from state.
- Minimum 4 cycles per instruction (ack in the first FETCH cycle). Each wait cycle on imem_ack adds 1.
- ack arriving while imem_req=0 is ignored.
- pc changes only on the WB->FETCH edge. retired increments on the same edge.
- rst asserted in any state, mid-fetch included, returns every register to its reset value on that edge. No rf_we pulse is emitted, and a pending fetch is abandoned.
- halted and halt_code update on the DECODE->HALT (or FETCH->HALT) edge.

## Configuration
- SEQ_FETCH_TIMEOUT_EN defined:
  - An 8+-bit counter clears on entry to FETCH and increments each FETCH cycle without ack.
  - When it reaches FETCH_TIMEOUT with no ack, the state moves to HALT with halt_code=3.
  - An ack on the same cycle as the limit wins.
- SEQ_FETCH_TIMEOUT_EN undefined: FETCH waits indefinitely, the counter is not built, and halt_code=3 is unreachable.

## Test plan
- Reset: hold rst 2 cycles -> pc=0x8000_0000, retired=0, halted=0, imem_req=0. Start is then ignored until asserted.
- addi x1,x0,5 (0x0050_0093) with zero-wait ack:
  - FETCH->DECODE->EXEC->WB in 4 cycles; inst_type=1.
  - rf_we pulses exactly in WB.
  - pc becomes 0x8000_0004 and retired=1.
- addi x0,x0,0 (0x0000_0013): inst_type=1, rf_we stays 0, pc advances by 4. Then sw (0x0011_2023): inst_type=2, rf_we=0.
- jal with jump_valid=1, jump_target=0x8000_0100 in EXEC -> next imem_addr=0x8000_0100. A 3-cycle ack delay gives a 7-cycle instruction.
- ebreak -> halted=1, halt_code=1, no further imem_req. Opcode 0x0000_0000 -> halt_code=2. rst then recovers to IDLE.
- With SEQ_FETCH_TIMEOUT_EN, FETCH_TIMEOUT=4, ack never asserted -> halt_code=3 after 4 FETCH cycles. Separately, rst asserted mid-FETCH -> reset values on the next edge.
